// File: rtl/iopmp_prio_scan.sv
// iopmp_prio_scan: multi-cycle priority resolver for the IOPMP checker.
//
// Captures a match vector and per-entry R/W permissions on a valid/ready
// handshake. It then scans the captured vector CHUNK bits per cycle, with the
// lowest index winning. It returns the winning index and an allow/deny
// decision on a second valid/ready handshake.
//
// Optional build macro: IOPMP_PRIO_SCAN_STATS_EN adds deny_cnt_o, a saturating
// 16-bit count of denied decisions that were handed off.
module iopmp_prio_scan #(
    parameter  int NUM_ENTRIES = 16,
    parameter  int CHUNK       = 4,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NUM_ENTRIES-1:0] match_i,
    input  logic [NUM_ENTRIES-1:0] perm_r_i,
    input  logic [NUM_ENTRIES-1:0] perm_w_i,
    input  logic                   is_write_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   hit_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   allow_o,
`ifdef IOPMP_PRIO_SCAN_STATS_EN
    output logic [15:0]            deny_cnt_o,
`endif
    output logic                   busy_o
);

    localparam int NUM_CHUNKS = (NUM_ENTRIES + CHUNK - 1) / CHUNK;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int TZ_W       = $clog2(CHUNK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_ENTRIES-1:0] match_q;
    logic [NUM_ENTRIES-1:0] perm_r_q;
    logic [NUM_ENTRIES-1:0] perm_w_q;
    logic                   is_write_q;

    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic                   hit_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   allow_q;

    // Scan datapath signals, all derived from the captured registers.
    logic [PAD_W-1:0]       match_pad;
    logic [CHUNK-1:0]       win;
    logic                   win_nz;
    logic [TZ_W-1:0]        tz;
    logic [31:0]            pos;
    logic [IDX_W-1:0]       idx_d;
    logic                   allow_d;
    logic                   last_chunk;

    // Zero-pad the top of the last chunk so bits past the real entries never win.
    genvar gi;
    generate
        for (gi = 0; gi < PAD_W; gi++) begin : g_pad
            if (gi < NUM_ENTRIES) begin : g_real
                assign match_pad[gi] = match_q[gi];
            end else begin : g_zero
                assign match_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign win        = match_pad[cnt_q*CHUNK +: CHUNK];
    assign win_nz     = |win;
    assign last_chunk = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

    // Trailing-zero count of the current window: a downward scan leaves the lowest set bit.
    always_comb begin
        tz = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (win[i]) begin
                tz = TZ_W'(i);
            end
        end
    end

    // Winning index and its permission for the request type. This is only used when win_nz is set.
    always_comb begin
        pos     = 32'(cnt_q) * 32'(CHUNK) + 32'(tz);
        idx_d   = pos[IDX_W-1:0];
        allow_d = is_write_q ? perm_w_q[idx_d] : perm_r_q[idx_d];
    end

    // Control FSM: capture on the input handshake, scan one chunk per cycle, hold the result until the output handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            match_q     <= '0;
            perm_r_q    <= '0;
            perm_w_q    <= '0;
            is_write_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            allow_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        match_q    <= match_i;
                        perm_r_q   <= perm_r_i;
                        perm_w_q   <= perm_w_i;
                        is_write_q <= is_write_i;
                        cnt_q      <= '0;
                        state_q    <= S_SCAN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (win_nz) begin
                        hit_q       <= 1'b1;
                        idx_q       <= idx_d;
                        allow_q     <= allow_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (last_chunk) begin
                        hit_q       <= 1'b0;
                        idx_q       <= '0;
                        allow_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign hit_o       = hit_q;
    assign idx_o       = idx_q;
    assign allow_o     = allow_q;

`ifdef IOPMP_PRIO_SCAN_STATS_EN
    logic [15:0] deny_cnt_q;

    // Count denied decisions at handoff; saturate rather than wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deny_cnt_q <= '0;
        end else if (out_valid_q && out_ready_i && !allow_q && (deny_cnt_q != 16'hFFFF)) begin
            deny_cnt_q <= deny_cnt_q + 16'd1;
        end
    end

    assign deny_cnt_o = deny_cnt_q;
`endif

endmodule

// File: tb/tb_iopmp_prio_scan.sv
// Directed bench for iopmp_prio_scan (NUM_ENTRIES=16, CHUNK=4).
module tb_iopmp_prio_scan;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] match_i;
    logic [15:0] perm_r_i;
    logic [15:0] perm_w_i;
    logic        is_write_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        hit_o;
    logic [3:0]  idx_o;
    logic        allow_o;
    logic        busy_o;
`ifdef IOPMP_PRIO_SCAN_STATS_EN
    logic [15:0] deny_cnt_o;
`endif

    iopmp_prio_scan #(.NUM_ENTRIES(16), .CHUNK(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .match_i     (match_i),
        .perm_r_i    (perm_r_i),
        .perm_w_i    (perm_w_i),
        .is_write_i  (is_write_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .hit_o       (hit_o),
        .idx_o       (idx_o),
        .allow_o     (allow_o),
`ifdef IOPMP_PRIO_SCAN_STATS_EN
        .deny_cnt_o  (deny_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] match;
        logic [15:0] pr;
        logic [15:0] pw;
        logic        wr;
        logic        exp_hit;
        logic [3:0]  exp_idx;
        logic        exp_allow;
        int          exp_lat;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_deny = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, measure latency, check the decision, then hand it off.
    task automatic run_req(input vec_t v, input int id);
        int lat;
        @(negedge clk_i);
        check("in_ready_before_req", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        match_i    = v.match;
        perm_r_i   = v.pr;
        perm_w_i   = v.pw;
        is_write_i = v.wr;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        // Scramble inputs: they must not affect the captured request.
        match_i    = ~v.match;
        perm_r_i   = ~v.pr;
        perm_w_i   = ~v.pw;
        is_write_i = ~v.wr;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(v.exp_lat));
        check("hit", 32'(hit_o), 32'(v.exp_hit));
        check("idx", 32'(idx_o), 32'(v.exp_idx));
        check("allow", 32'(allow_o), 32'(v.exp_allow));
        check("busy_in_done", 32'(busy_o), 32'd1);
        $display("req %0d: match=%h wr=%0d -> lat=%0d hit=%0d idx=%0d allow=%0d", id, v.match, v.wr, lat, hit_o, idx_o, allow_o);
        if (!allow_o) n_deny++;
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check("out_valid_after_handoff", 32'(out_valid_o), 32'd0);
        check("in_ready_after_handoff", 32'(in_ready_o), 32'd1);
    endtask

    vec_t vecs [8];

    initial begin
        vec_t v;
        logic [3:0] held_idx;
        logic       held_hit;
        logic       held_allow;
        int         spurious;

        vecs[0] = '{16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 4'd0,  1'b1, 2};
        vecs[1] = '{16'h8400, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 4'd10, 1'b0, 4};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 4'd0,  1'b0, 5};
        vecs[3] = '{16'h0030, 16'h0020, 16'hFFFF, 1'b0, 1'b1, 4'd4,  1'b0, 3};
        vecs[4] = '{16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1, 4'd15, 1'b1, 5};
        vecs[5] = '{16'h0808, 16'h0008, 16'h0000, 1'b0, 1'b1, 4'd3,  1'b1, 2};
        vecs[6] = '{16'h0100, 16'h0000, 16'h0100, 1'b1, 1'b1, 4'd8,  1'b1, 4};
        vecs[7] = '{16'h4000, 16'hBFFF, 16'hFFFF, 1'b0, 1'b1, 4'd14, 1'b0, 5};

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        match_i = '0; perm_r_i = '0; perm_w_i = '0; is_write_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_hit", 32'(hit_o), 32'd0);
        check("rst_idx", 32'(idx_o), 32'd0);
        check("rst_allow", 32'(allow_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i], i);
        end

        // Hold the decision for 5 cycles with out_ready low while match_i toggles.
        v = '{16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd1, 1'b0, 2};
        @(negedge clk_i);
        in_valid_i = 1'b1; match_i = v.match; perm_r_i = v.pr; perm_w_i = v.pw; is_write_i = v.wr;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("hold_valid_at_lat2", 32'(out_valid_o), 32'd1);
        held_hit = hit_o; held_idx = idx_o; held_allow = allow_o;
        check("hold_idx_value", 32'(idx_o), 32'd1);
        n_deny++;
        for (int k = 0; k < 5; k++) begin
            match_i = ~match_i;
            @(posedge clk_i);
            #1;
            check("hold_valid", 32'(out_valid_o), 32'd1);
            check("hold_in_ready", 32'(in_ready_o), 32'd0);
            check("hold_outputs", {29'd0, hit_o, allow_o, 1'b0} | 32'(idx_o) << 8,
                  {29'd0, held_hit, held_allow, 1'b0} | 32'(held_idx) << 8);
        end
        $display("hold: idx=%0d stable over 5 stalled cycles", idx_o);
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check("hold_release_in_ready", 32'(in_ready_o), 32'd1);
        check("hold_release_busy", 32'(busy_o), 32'd0);

        // Reset in the middle of a scan at chunk 2; no decision may appear.
        @(negedge clk_i);
        in_valid_i = 1'b1; match_i = 16'h0000;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("midscan_rst_in_ready", 32'(in_ready_o), 32'd1);
        check("midscan_rst_out_valid", 32'(out_valid_o), 32'd0);
        check("midscan_rst_busy", 32'(busy_o), 32'd0);
        spurious = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o) spurious++;
        end
        check("no_decision_after_rst", 32'(spurious), 32'd0);
        $display("reset mid-scan: dropped, spurious outputs=%0d", spurious);
`ifdef IOPMP_PRIO_SCAN_STATS_EN
        n_deny = 0;
`endif
        run_req(vecs[1], 8);

`ifdef IOPMP_PRIO_SCAN_STATS_EN
        check("deny_cnt", 32'(deny_cnt_o), 32'(n_deny));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
